// File: rtl/piggy_uart_pkg.sv
// piggy_uart_pkg: definitions shared by the piggy-bank UART receive and transmit paths.
package piggy_uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam logic [7:0] CMD_REPORT_DEF = 8'h53;
    localparam logic [7:0] CMD_CLEAR_DEF  = 8'h43;

    // True while a frame is in flight; BREAK is deliberately excluded.
    function automatic logic rx_busy(input rx_state_e s);
        return s inside {RX_START, RX_DATA, RX_STOP};
    endfunction

endpackage

// File: rtl/uart_rx_cmd_if.sv
// uart_rx_cmd_if: serial input and decoded byte/command outputs of the UART receiver.
interface uart_rx_cmd_if;
    logic       i_Rx_Serial;
    logic       o_Rx_Active;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Frame_Err;
    logic       o_cmd_report;
    logic       o_cmd_clear;

    modport master (
        input  i_Rx_Serial,
        output o_Rx_Active, o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_cmd_report, o_cmd_clear
    );

    modport slave (
        output i_Rx_Serial,
        input  o_Rx_Active, o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_cmd_report, o_cmd_clear
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser that resets to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= 2'b11;
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver with mid-bit sampling, framing-error flag and
// single-byte report/clear command decode.
module uart_rx_cmd
    import piggy_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 87,
    parameter logic [7:0] CMD_REPORT   = CMD_REPORT_DEF,
    parameter logic [7:0] CMD_CLEAR    = CMD_CLEAR_DEF
) (
    input logic           clk,
    input logic           rst,
    uart_rx_cmd_if.master bus
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state, state_d;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          half_hit, bit_hit;
    logic          active_d, dv_d, err_d, report_d, clear_d;
    logic [7:0]    byte_d;
    logic          active_q, dv_q, err_q, report_q, clear_q;
    logic [7:0]    byte_q;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.i_Rx_Serial),
        .q   (rx_s)
    );

    assign half_hit = clk_cnt == HALF;
    assign bit_hit  = clk_cnt == LAST;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= RX_IDLE;
        else     state <= state_d;

    always_comb begin
        state_d = state;
        case (state)
            RX_IDLE:  if (!rx_s) state_d = RX_START;
            RX_START: if (half_hit) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_hit && bit_idx == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (bit_hit) state_d = rx_s ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rx_s) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // The bit counter restarts on every state change and on each data-bit boundary.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            clk_cnt <= (state_d != state || bit_hit || !rx_busy(state)) ? '0 : clk_cnt + 1'b1;
            bit_idx <= (state == RX_DATA) ? bit_idx + 3'(bit_hit) : '0;
            if (state == RX_DATA && bit_hit) shift_reg[bit_idx] <= rx_s;
        end

    always_comb begin
        dv_d     = state == RX_STOP && bit_hit && rx_s;
        err_d    = state == RX_STOP && bit_hit && !rx_s;
        report_d = dv_d && shift_reg == CMD_REPORT;
        clear_d  = dv_d && shift_reg == CMD_CLEAR;
        byte_d   = dv_d ? shift_reg : byte_q;
        active_d = rx_busy(state);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {active_q, dv_q, err_q, report_q, clear_q} <= '0;
            byte_q <= '0;
        end else begin
            {active_q, dv_q, err_q, report_q, clear_q} <= {active_d, dv_d, err_d, report_d, clear_d};
            byte_q <= byte_d;
        end

    assign bus.o_Rx_Active    = active_q;
    assign bus.o_Rx_DV        = dv_q;
    assign bus.o_Rx_Byte      = byte_q;
    assign bus.o_Rx_Frame_Err = err_q;
    assign bus.o_cmd_report   = report_q;
    assign bus.o_cmd_clear    = clear_q;
endmodule

// File: tb/tb_uart_rx_cmd.sv
// tb_uart_rx_cmd: directed and randomized frames against a frame-level timing/decode model.
module tb_uart_rx_cmd;
    localparam int         C       = 4;
    localparam int         H       = (C - 1) / 2;
    localparam int         LAT     = 3 + H + 9 * C;
    localparam logic [7:0] CMD_REP = 8'h53;
    localparam logic [7:0] CMD_CLR = 8'h43;

    typedef struct {
        int         cyc;
        logic       dv, err, rep, clr;
        logic [7:0] b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] last_byte = 8'h00;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    bit   act_hist[int];

    uart_rx_cmd_if bus ();

    uart_rx_cmd #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every pulse is logged with the index of the edge that produced it.
    always @(negedge clk) begin
        act_hist[cyc] = bus.o_Rx_Active;
        if (bus.o_Rx_DV || bus.o_Rx_Frame_Err || bus.o_cmd_report || bus.o_cmd_clear)
            obs_q.push_back('{cyc, bus.o_Rx_DV, bus.o_Rx_Frame_Err, bus.o_cmd_report,
                              bus.o_cmd_clear, bus.o_Rx_Byte});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_frame(input int t0, input logic [7:0] b, input bit ok);
        ev_t e;
        e.cyc = t0 + LAT;
        e.dv  = ok;
        e.err = !ok;
        e.rep = ok && b == CMD_REP;
        e.clr = ok && b == CMD_CLR;
        e.b   = ok ? b : last_byte;
        exp_q.push_back(e);
        if (ok) last_byte = b;
    endtask

    // Must be called at a falling edge; the pin falls just before edge t0.
    task automatic send(input logic [7:0] b, input bit ok, output int t0);
        logic [9:0] f;
        f  = {ok, b, 1'b0};
        t0 = cyc + 1;
        expect_frame(t0, b, ok);
        for (int i = 0; i < 10; i++) begin
            bus.i_Rx_Serial = f[i];
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.i_Rx_Serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        check($sformatf("%s count", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s[%0d] cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s[%0d] dv", tag, i), obs_q[i].dv, exp_q[i].dv);
            check($sformatf("%s[%0d] err", tag, i), obs_q[i].err, exp_q[i].err);
            check($sformatf("%s[%0d] rep", tag, i), obs_q[i].rep, exp_q[i].rep);
            check($sformatf("%s[%0d] clr", tag, i), obs_q[i].clr, exp_q[i].clr);
            check($sformatf("%s[%0d] byte", tag, i), obs_q[i].b, exp_q[i].b);
        end
        obs_q.delete();
        exp_q.delete();
        check($sformatf("%s held byte", tag), bus.o_Rx_Byte, last_byte);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " active"}, bus.o_Rx_Active, 1'b0);
        check({tag, " dv"}, bus.o_Rx_DV, 1'b0);
        check({tag, " byte"}, bus.o_Rx_Byte, 8'h00);
        check({tag, " err"}, bus.o_Rx_Frame_Err, 1'b0);
        check({tag, " rep"}, bus.o_cmd_report, 1'b0);
        check({tag, " clr"}, bus.o_cmd_clear, 1'b0);
    endtask

    initial begin
        int t0, t1;
        logic [7:0] b;
        bit ok;
        bus.i_Rx_Serial = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(4);

        send(8'hA5, 1'b1, t0);
        idle(6);
        drain("a5");
        check("a5 active t0+2", act_hist[t0 + 2], 1'b0);
        check("a5 active t0+3", act_hist[t0 + 3], 1'b1);
        check("a5 active mid", act_hist[t0 + 20], 1'b1);
        check("a5 active dv", act_hist[t0 + LAT], 1'b1);
        check("a5 active after", act_hist[t0 + LAT + 1], 1'b0);

        send(CMD_REP, 1'b1, t0);
        send(CMD_CLR, 1'b1, t1);
        idle(6);
        check("b2b spacing", t1 - t0, 10 * C);
        drain("b2b");

        bus.i_Rx_Serial = 1'b0;
        @(negedge clk);
        idle(8);
        drain("glitch");
        send(8'h11, 1'b1, t0);
        idle(6);
        drain("after glitch");

        send(8'h3C, 1'b0, t0);
        bus.i_Rx_Serial = 1'b0;
        repeat (30) @(negedge clk);
        idle(8);
        drain("break");
        send(CMD_CLR, 1'b1, t0);
        idle(6);
        drain("after break");

        t0 = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            bus.i_Rx_Serial = (i == 0) ? 1'b0 : 1'b1;
            repeat (C) @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.i_Rx_Serial = 1'b1;
        #1;
        check_reset_outputs("midframe rst");
        repeat (3) @(negedge clk);
        check_reset_outputs("held rst");
        rst = 1'b0;
        last_byte = 8'h00;
        idle(60);
        drain("aborted");
        send(CMD_REP, 1'b1, t0);
        idle(6);
        drain("after rst");

        send(8'h73, 1'b1, t0);
        idle(6);
        drain("lowercase s");

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: b = CMD_REP;
                1: b = CMD_CLR;
                default: b = 8'($urandom);
            endcase
            ok = $urandom_range(0, 5) != 0;
            send(b, ok, t0);
            if (!ok) idle(4);
            idle($urandom_range(0, 5));
        end
        idle(8);
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
Serial receive path for the piggy-bank UART link, the counterpart to the existing TX FSM on the same 8N1 line. It deserialises host bytes using mid-bit sampling and flags framing errors. It decodes two single-byte commands: report, which requests a fresh balance transmission, and clear, which requests a counter reset. It sits beside the TX FSM in the top level; its command pulses are ORed into start_sending and into the counters' clear logic.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); must be >= 4
CMD_REPORT, 8'h53, byte ('S') that requests a balance report
CMD_CLEAR, 8'h43, byte ('C') that requests a counter clear

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_Rx_Serial  in  1  UART line, idle high, asynchronous to clk
o_Rx_Active  out  1  high while a frame is being received (START, DATA or STOP)
o_Rx_DV  out  1  one-cycle pulse: valid byte on o_Rx_Byte
o_Rx_Byte  out  8  last correctly framed byte; held until the next valid frame
o_Rx_Frame_Err  out  1  one-cycle pulse: stop bit sampled low
o_cmd_report  out  1  one-cycle pulse, coincident with o_Rx_DV, when byte == CMD_REPORT
o_cmd_clear  out  1  one-cycle pulse, coincident with o_Rx_DV, when byte == CMD_CLEAR

Behaviour:
- Reset (async, rst=1):
  - both synchroniser flops are set to 1 (idle line), so no false start bit after reset.
  - state=IDLE, all counters 0.
  - all outputs 0, including o_Rx_Byte=8'h00.
- Synchroniser: 2-flop; rx_s is the second flop. All decisions use rx_s only.
- H = (CLKS_PER_BIT-1)/2, integer division. clk_cnt resets to 0 on every state change.
- IDLE: if rx_s==0, go to START.
- START: when clk_cnt==H:
  - if rx_s==0, go to DATA with bit_idx=0.
  - else go to IDLE (glitch rejected, no output pulse).
- DATA: when clk_cnt==CLKS_PER_BIT-1:
  - shift_reg[bit_idx] <= rx_s (LSB first).
  - if bit_idx==7, go to STOP; else bit_idx++.
- STOP: when clk_cnt==CLKS_PER_BIT-1:
  - if rx_s==1: o_Rx_Byte <= shift_reg, and o_Rx_DV plus any matching command pulse assert for exactly the next cycle; go to IDLE.
  - if rx_s==0: o_Rx_Frame_Err pulses for one cycle, o_Rx_Byte is unchanged, no command pulses; go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line (break) therefore produces exactly one error and no further frames.
- Exact latency: if the pin falls just before edge t0, o_Rx_DV is high in the cycle after edge t0 + 3 + H + 9*CLKS_PER_BIT. For CLKS_PER_BIT=4 that is t0+40.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. The IDLE to START transition costs no extra bit time.
- Reset mid-frame:
  - immediate return to IDLE.
  - no DV or error pulse is produced for the aborted frame.
  - o_Rx_Byte clears to 0.
- Command decode: uses only the full 8-bit value ('s' lowercase is not a command). Unknown bytes assert DV only.
- Counters: clk_cnt width is $clog2(CLKS_PER_BIT); bit_idx is 3 bits. Neither wraps within a state.

Decomposition:
- Shared package piggy_uart_pkg:
  - rx state encoding (IDLE, START, DATA, STOP, BREAK).
  - CMD_REPORT / CMD_CLEAR default constants, which the TX side also uses for echo/report framing.
- Sub-module uart_rx_sync: a 2-flop synchroniser with reset value 1. Everything else stays in one module.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
1. Send 0xA5 with the pin falling before edge t0 -> o_Rx_DV high exactly at cycle t0+40 for 1 cycle, o_Rx_Byte=0xA5, both cmd outputs 0, o_Rx_Active high from t0+3 to the DV cycle.
2. Send 0x53, then 0x43 back-to-back with no idle gap -> two DV pulses 40 cycles apart; o_cmd_report coincides with the first, o_cmd_clear with the second; o_Rx_Byte ends at 0x43.
3. Pulse the line low for 1 cycle -> state returns to IDLE; no DV or error; a following 0x11 frame is received correctly.
4. Send 0x3C with the stop bit low, hold the line low 30 cycles, release, then send 0x43 -> exactly one o_Rx_Frame_Err pulse; o_Rx_Byte unchanged; then DV with 0x43 and o_cmd_clear.
5. Assert rst during bit 4 of 0xFF, release, then send 0x53 -> no pulses from the aborted frame; all outputs 0 during reset; DV with 0x53 and o_cmd_report follows.
6. Send 0x73 ('s') -> DV with 0x73; o_cmd_report stays 0.
